// File: rtl/sha256_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_constants (package)
//  Description : Shared SHA-256 constants, state typedefs and round helper
//                functions used by the block sequencer and its round datapath.
//                Contents: K[0:63] round constants, H_INIT[0:7] initial hash,
//                hstate_t (eight 32-bit words, index 0 = a / H0),
//                seq_state_t sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha256_constants;

  // Eight 32-bit words; element 0 occupies the most significant bits.
  typedef logic [0:7][31:0] hstate_t;

  // PASS2 is always part of the encoding, even when double hashing is absent.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROUND = 3'd1,
    ACC   = 3'd2,
    PASS2 = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hstate_t H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_block_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_block_sequencer_if
//  Description : Job / digest handshake bundle of the SHA-256 block sequencer.
//                master : job feeder + digest consumer side
//                slave  : sequencer side
//                Signals: abort, job_valid/job_ready/job_two_blk/job_msg,
//                digest_valid/digest_ready/digest, busy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha256_block_sequencer_if;
  logic          abort;
  logic          job_valid;
  logic          job_ready;
  logic          job_two_blk;
  logic [0:1023] job_msg;      // [0:511] block 0, [512:1023] block 1
  logic          digest_valid;
  logic          digest_ready;
  logic [0:255]  digest;       // H0 in [0:31] ... H7 in [224:255]
  logic          busy;

  modport master (
    output abort, job_valid, job_two_blk, job_msg, digest_ready,
    input  job_ready, digest_valid, digest, busy
  );

  modport slave (
    input  abort, job_valid, job_two_blk, job_msg, digest_ready,
    output job_ready, digest_valid, digest, busy
  );
endinterface
`default_nettype wire

// File: rtl/sha256_block_sequencer_round.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round
//  Description : One combinational SHA-256 compression round.
//                state_in  : working variables a..h (index 0 = a)
//                w, k      : message schedule word and round constant
//                state_out : updated a'..h'
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_round
  import sha256_constants::*;
(
  input  wire hstate_t     state_in,
  input  wire logic [31:0] w,
  input  wire logic [31:0] k,
  output hstate_t          state_out
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = state_in[7] + bsig1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6]) + k + w;
  assign w_t2 = bsig0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);

  assign state_out = {w_t1 + w_t2, state_in[0], state_in[1], state_in[2],
                      state_in[3] + w_t1, state_in[4], state_in[5], state_in[6]};

endmodule
`default_nettype wire

// File: rtl/sha256_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_block_sequencer
//  Description : Iterative SHA-256 engine controller. Accepts a pre-padded
//                1- or 2-block job, runs 64 rounds per block over RPC chained
//                round instances, accumulates the chaining state and returns
//                the digest over a valid/ready handshake.
//                Ports: clk, rst_n (async, active low), bus (slave modport of
//                sha256_block_sequencer_if).
//                Parameter RPC: rounds per cycle (1, 2 or 4).
//                Optional macro SHA256_DOUBLE_HASH_EN: hash the 256-bit
//                result a second time (PASS2) before reporting it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_block_sequencer
  import sha256_constants::*;
#(
  parameter int RPC = 1
)
(
  input wire logic                 clk,
  input wire logic                 rst_n,
  sha256_block_sequencer_if.slave  bus
);

  generate
    if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_rpc_check
      $error("sha256_block_sequencer: RPC must be 1, 2 or 4");
    end
  endgenerate

  seq_state_t              r_state;
  seq_state_t              w_next;
  logic [6:0]              r_t;
  logic [6:0]              w_t_next;
  logic                    r_two_blk;
  logic                    r_blk;
  logic [0:1023]           r_msg;
  logic [0:15][31:0]       r_w;       // W[t .. t+15]
  hstate_t                 r_h;
  hstate_t                 r_wk;
  hstate_t                 w_hsum;
  logic [0:15+RPC][31:0]   w_ext;     // W[t .. t+15+RPC]
  hstate_t                 w_chain [0:RPC];
`ifdef SHA256_DOUBLE_HASH_EN
  logic                    r_pass2;
  logic [0:15][31:0]       w_pass2_blk;

  // Second-pass block: 256-bit digest, padding bit, length = 256 bits.
  assign w_pass2_blk = {r_h, 32'h80000000, {6{32'h0}}, 32'h00000100};
`endif

  assign w_t_next = r_t + 7'(RPC);

  always_comb begin
    w_hsum = '0;
    for (int i = 0; i < 8; i++) w_hsum[i] = r_h[i] + r_wk[i];
  end

  // Extend the window by RPC words; later words may depend on earlier new
  // ones within the same cycle, so the chain is evaluated in order.
  always_comb begin
    w_ext = '0;
    w_ext[0:15] = r_w;
    for (int j = 0; j < RPC; j++)
      w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
  end

  assign w_chain[0] = r_wk;

  generate
    for (genvar g = 0; g < RPC; g++) begin : g_round
      logic [31:0] w_k;
      assign w_k = K[r_t[5:0] + 6'(g)];
      sha256_round u_round (
        .state_in  (w_chain[g]),
        .w         (w_ext[g]),
        .k         (w_k),
        .state_out (w_chain[g+1])
      );
    end
  endgenerate

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (bus.job_valid) w_next = ROUND;
        ROUND: if (w_t_next == 7'd64) w_next = ACC;
        ACC: begin
          if (!r_blk && r_two_blk) w_next = ROUND;
`ifdef SHA256_DOUBLE_HASH_EN
          else if (!r_pass2)       w_next = PASS2;
`endif
          else                     w_next = DONE;
        end
        PASS2: w_next = ROUND;
        DONE:  if (bus.digest_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.job_ready    = rst_n && !bus.abort && (r_state == IDLE);
    bus.digest_valid = (r_state == DONE);
    bus.busy         = (r_state != IDLE);
  end

  assign bus.digest = r_h;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t       <= '0;
      r_two_blk <= 1'b0;
      r_blk     <= 1'b0;
      r_msg     <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_wk      <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
      r_pass2   <= 1'b0;
`endif
    end else if (!bus.abort) begin
      case (r_state)
        IDLE: begin
          if (bus.job_valid) begin
            r_msg     <= bus.job_msg;
            r_two_blk <= bus.job_two_blk;
            r_blk     <= 1'b0;
            r_t       <= '0;
            r_h       <= H_INIT;
            r_wk      <= H_INIT;
            r_w       <= bus.job_msg[0:511];
`ifdef SHA256_DOUBLE_HASH_EN
            r_pass2   <= 1'b0;
`endif
          end
        end
        ROUND: begin
          r_wk <= w_chain[RPC];
          r_w  <= w_ext[RPC:RPC+15];
          r_t  <= w_t_next;
        end
        ACC: begin
          r_h <= w_hsum;
          if (!r_blk && r_two_blk) begin
            r_blk <= 1'b1;
            r_wk  <= w_hsum;
            r_t   <= '0;
            r_w   <= r_msg[512:1023];
          end
        end
`ifdef SHA256_DOUBLE_HASH_EN
        PASS2: begin
          r_w     <= w_pass2_blk;
          r_h     <= H_INIT;
          r_wk    <= H_INIT;
          r_t     <= '0;
          r_blk   <= 1'b1;
          r_pass2 <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_block_sequencer
//  Description : Self-checking bench for sha256_block_sequencer. Two DUTs
//                (RPC=1 and RPC=4) share stimulus; expected digests are queued
//                when a job is offered and compared at the digest handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_block_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_block_sequencer_if if1 ();
  sha256_block_sequencer_if if4 ();

  logic          abort   = 1'b0;
  logic          two_blk = 1'b0;
  logic          dready  = 1'b1;
  logic          v1      = 1'b0;
  logic          v4      = 1'b0;
  logic [0:1023] msg     = '0;
  logic          sel     = 1'b0;

  assign if1.abort = abort;  assign if1.job_valid = v1;  assign if1.job_two_blk = two_blk;
  assign if1.job_msg = msg;  assign if1.digest_ready = dready;
  assign if4.abort = abort;  assign if4.job_valid = v4;  assign if4.job_two_blk = two_blk;
  assign if4.job_msg = msg;  assign if4.digest_ready = dready;

  sha256_block_sequencer #(.RPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sha256_block_sequencer #(.RPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  logic         o_dv, o_jr, o_busy;
  logic [0:255] o_dig;
  assign o_dv   = sel ? if4.digest_valid : if1.digest_valid;
  assign o_jr   = sel ? if4.job_ready    : if1.job_ready;
  assign o_busy = sel ? if4.busy         : if1.busy;
  assign o_dig  = sel ? if4.digest       : if1.digest;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int t_acc    = 0;
  logic [0:255] exp_q [$];

  localparam logic [0:1023] M_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018, 512'h0};
  localparam logic [0:1023] M_EMPTY = {32'h80000000, {15{32'h0}}, 512'h0};
  localparam logic [0:1023] M_TWO   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
                                       {15{32'h0}}, 32'h000001c0};
`ifdef SHA256_DOUBLE_HASH_EN
  localparam logic [0:255] D_ABC   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [0:255] D_EMPTY = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
`else
  localparam logic [0:255] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [0:255] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [0:255] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`endif

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a job for one cycle to the selected DUT (d4=1 -> RPC=4 instance).
  task automatic start_job(input logic d4, input logic [0:1023] m, input logic tb2,
                           input logic [0:255] expd, input bit push);
    sel = d4; msg = m; two_blk = tb2;
    chk("job_ready_idle", o_jr, 1);
    if (d4) v4 = 1'b1; else v1 = 1'b1;
    if (push) exp_q.push_back(expd);
    step();
    v1 = 1'b0; v4 = 1'b0;
    t_acc = cyc;
    chk("busy_after_accept", o_busy, 1);
  endtask

  task automatic wait_valid(input int lat, input string tag);
    int i = 0;
    while (!o_dv && i < 400) begin step(); i++; end
    chk({tag, "_valid"}, o_dv, 1);
    chk({tag, "_latency"}, cyc - t_acc, lat);
  endtask

  task automatic take_digest(input string tag);
    logic [0:255] e = '0;
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_digest"}, o_dig, e);
    dready = 1'b1;
    step();
    chk({tag, "_idle_after"}, o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_job_ready", o_jr, 1);
      chk("rst_digest_valid", o_dv, 0);
      chk("rst_digest", o_dig, 0);
      chk("rst_busy", o_busy, 0);
    end
    step();

`ifdef SHA256_DOUBLE_HASH_EN
    start_job(0, M_ABC, 0, D_ABC, 1);   wait_valid(131, "dh_abc");   take_digest("dh_abc");
    start_job(1, M_EMPTY, 0, D_EMPTY, 1); wait_valid(35, "dh_empty"); take_digest("dh_empty");
`else
    // basic vectors
    start_job(0, M_ABC, 0, D_ABC, 1);     wait_valid(65, "abc");       take_digest("abc");
    start_job(1, M_EMPTY, 0, D_EMPTY, 1); wait_valid(17, "empty4");    take_digest("empty4");
    start_job(0, M_TWO, 1, D_TWO, 1);     wait_valid(130, "two1");     take_digest("two1");
    start_job(1, M_TWO, 1, D_TWO, 1);     wait_valid(34, "two4");      take_digest("two4");

    // back-pressure in DONE
    dready = 1'b0;
    start_job(0, M_ABC, 0, D_ABC, 1);     wait_valid(65, "hold");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_valid_ready", {o_dv, o_jr}, 2'b10);
      chk("hold_digest", o_dig, D_ABC);
    end
    take_digest("hold");
    start_job(0, M_EMPTY, 0, D_EMPTY, 1); wait_valid(65, "b2b_a");     take_digest("b2b_a");
    start_job(0, M_ABC, 0, D_ABC, 1);     wait_valid(65, "b2b_b");     take_digest("b2b_b");

    // abort mid-job, abort in IDLE blocks acceptance
    start_job(0, M_TWO, 1, D_TWO, 0);
    repeat (30) step();
    chk("mid_busy", {o_busy, o_dv}, 2'b10);
    abort = 1'b1;
    sel = 1'b1; v4 = 1'b1;
    #1 chk("abort_idle_job_ready", o_jr, 0);
    step();
    chk("abort_idle_no_accept", o_busy, 0);
    abort = 1'b0; v4 = 1'b0; sel = 1'b0;
    #1 chk("abort_flush", {o_busy, o_dv}, 2'b00);
    start_job(0, M_ABC, 0, D_ABC, 1);     wait_valid(65, "post_abort"); take_digest("post_abort");

    // abort beats digest_ready
    dready = 1'b0;
    start_job(0, M_ABC, 0, D_ABC, 0);     wait_valid(65, "abort_done");
    dready = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0;
    #1 chk("abort_done_flush", {o_busy, o_dv}, 2'b00);

    // reset mid-job
    start_job(0, M_TWO, 1, D_TWO, 0);
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {o_dv, o_jr, o_busy}, 3'b000);
    chk("rst_mid_digest", o_dig, 0);
    step();
    rst_n = 1'b1;
    step();
    start_job(0, M_ABC, 0, D_ABC, 1);     wait_valid(65, "post_rst");  take_digest("post_rst");
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
